// File: rtl/floor_request_latch.sv
// Floor-call button front end: synchronise, debounce and edge-detect each button,
// then hold a pending request until the elevator services that floor.
module floor_request_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_FLOORS      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic                  door_open,
  input  logic [1:0]            curr_floor,
  output logic [NUM_FLOORS-1:0] req,
  output logic [NUM_FLOORS-1:0] lamp,
  output logic [2:0]            req_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_FLOORS-1:0] s1, s2, db;
  logic [NUM_FLOORS-1:0] rise, clr, req_next;
  logic [CW-1:0]         cnt [NUM_FLOORS];
  logic [2:0]            count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TERM) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear dominates a same-cycle press so a call at the open-door floor is absorbed.
  always_comb begin
    rise       = '0;
    clr        = '0;
    req_next   = '0;
    count_next = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      rise[i]     = s2[i] && !db[i] && (cnt[i] == TERM);
      clr[i]      = door_open && (curr_floor == 2'(i));
      req_next[i] = (req[i] | rise[i]) & ~clr[i];
      count_next  = count_next + {2'b00, req_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req       <= '0;
      req_count <= '0;
    end else begin
      req       <= req_next;
      req_count <= count_next;
    end
  end

  assign lamp = req;

endmodule

// File: tb/tb_floor_request_latch.sv
// Directed bench for floor_request_latch: stimulus pushes expected req/count values
// tagged with the cycle they are due; a negedge monitor pops and compares them.
module tb_floor_request_latch;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       door_open;
  logic [1:0] curr_floor;
  logic [3:0] req;
  logic [3:0] lamp;
  logic [2:0] req_count;

  floor_request_latch #(.DEBOUNCE_CYCLES(4), .NUM_FLOORS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .door_open  (door_open),
    .curr_floor (curr_floor),
    .req        (req),
    .lamp       (lamp),
    .req_count  (req_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] r;
    logic [2:0] c;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   drain  = 0;
  bit   done_stim = 0;
  bit   finished  = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int d, input logic [3:0] r, input logic [2:0] c, input string nm);
    exp_t x;
    x.due  = cyc + d;
    x.r    = r;
    x.c    = c;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic cmp(input string nm, input string what, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s.%s at cycle %0d: got %0d expected %0d", nm, what, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due != cyc) begin
        cmp(e.name, "due_cycle", cyc, e.due);
      end else begin
        cmp(e.name, "req", int'(req), int'(e.r));
        cmp(e.name, "lamp", int'(lamp), int'(e.r));
        cmp(e.name, "req_count", int'(req_count), int'(e.c));
      end
    end
    if (done_stim && !finished) begin
      if (sb.size() == 0) begin
        finished = 1;
      end else begin
        drain++;
        if (drain > 200) begin
          cmp("drain", "pending_checks", sb.size(), 0);
          finished = 1;
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    btn        = 4'b0000;
    door_open  = 1'b0;
    curr_floor = 2'd0;
    tick(3);
    expect_at(0, 4'b0000, 3'd0, "reset_state");
    tick(1);
    reset = 1'b0;
    tick(2);

    // clean press on floor 2, then release
    btn = 4'b0100;
    expect_at(5, 4'b0000, 3'd0, "press_early");
    expect_at(6, 4'b0100, 3'd1, "press_lat");
    tick(8);
    btn = 4'b0000;
    tick(10);
    expect_at(0, 4'b0100, 3'd1, "release_keeps");
    tick(1);

    // bounce on floor 1: high 3, low 1, high 2
    btn = 4'b0010;
    tick(3);
    btn = 4'b0000;
    tick(1);
    btn = 4'b0010;
    tick(2);
    btn = 4'b0000;
    tick(10);
    expect_at(0, 4'b0100, 3'd1, "bounce_reject");
    tick(1);
    btn = 4'b0010;
    expect_at(5, 4'b0100, 3'd1, "steady_early");
    expect_at(6, 4'b0110, 3'd2, "steady_press");
    tick(4);
    btn = 4'b0000;
    tick(12);

    // build req=0101, then service floor 2
    door_open  = 1'b1;
    curr_floor = 2'd1;
    expect_at(1, 4'b0100, 3'd1, "clear_f1");
    tick(1);
    door_open = 1'b0;
    btn = 4'b0001;
    expect_at(6, 4'b0101, 3'd2, "press_f0");
    tick(8);
    btn = 4'b0000;
    tick(10);
    curr_floor = 2'd2;
    expect_at(2, 4'b0101, 3'd2, "no_door");
    tick(3);
    door_open = 1'b1;
    expect_at(1, 4'b0001, 3'd1, "svc_clear");
    tick(1);
    door_open = 1'b0;
    tick(1);

    // press on floors 3 and 0 landing with door open at floor 3
    door_open  = 1'b1;
    curr_floor = 2'd0;
    expect_at(1, 4'b0000, 3'd0, "clear_f0");
    tick(1);
    door_open = 1'b0;
    tick(1);
    btn = 4'b1001;
    tick(5);
    door_open  = 1'b1;
    curr_floor = 2'd3;
    expect_at(1, 4'b0001, 3'd1, "press_vs_clear");
    tick(1);
    door_open = 1'b0;
    expect_at(2, 4'b0001, 3'd1, "held_no_reset");
    tick(4);
    btn = 4'b0000;
    tick(12);

    // staggered multi-request, clear floor 1 while held, re-press
    door_open  = 1'b1;
    curr_floor = 2'd0;
    expect_at(1, 4'b0000, 3'd0, "clear_f0b");
    tick(1);
    door_open = 1'b0;
    tick(1);
    btn = 4'b0001;
    expect_at(6, 4'b0001, 3'd1, "multi_a");
    tick(2);
    btn = 4'b0011;
    expect_at(6, 4'b0011, 3'd2, "multi_b");
    tick(2);
    btn = 4'b1011;
    expect_at(6, 4'b1011, 3'd3, "multi_c");
    tick(8);
    door_open  = 1'b1;
    curr_floor = 2'd1;
    expect_at(1, 4'b1001, 3'd2, "clear_held");
    tick(1);
    door_open = 1'b0;
    tick(10);
    expect_at(0, 4'b1001, 3'd2, "hold_stays");
    btn = 4'b1001;
    tick(10);
    btn = 4'b1011;
    expect_at(5, 4'b1001, 3'd2, "repress_early");
    expect_at(6, 4'b1011, 3'd3, "repress");
    tick(8);

    // async reset mid-operation with req=1010, buttons still held
    door_open  = 1'b1;
    curr_floor = 2'd0;
    expect_at(1, 4'b1010, 3'd2, "clear_f0c");
    tick(1);
    door_open = 1'b0;
    tick(2);
    reset = 1'b1;
    expect_at(0, 4'b0000, 3'd0, "reset_async");
    expect_at(3, 4'b0000, 3'd0, "reset_held");
    tick(4);
    reset = 1'b0;
    expect_at(5, 4'b0000, 3'd0, "post_rst_early");
    expect_at(6, 4'b1011, 3'd3, "post_rst_press");
    tick(8);
    btn = 4'b0000;
    tick(4);

    done_stim = 1;
    wait (finished);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
